// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core (fetch + load/store units), the arbiter
// and the single-port block RAM. The slave modport is the arbiter's view;
// the master modport is the view of everything around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 13
);
  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_done;
  // data load/store port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wstrb;
  logic [31:0]       d_rdata;
  logic              d_done;
  // RAM side
  logic              m_rd_en;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_rd_data;
  logic              m_rd_valid;
  logic              m_wr_en;
  logic [31:0]       m_wr_data;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_rd_data, m_rd_valid,
    output i_rdata, i_done, d_rdata, d_done,
    output m_rd_en, m_addr, m_wr_en, m_wr_data
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_rd_data, m_rd_valid,
    input  i_rdata, i_done, d_rdata, d_done,
    input  m_rd_en, m_addr, m_wr_en, m_wr_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port
// 2048x32 block RAM. Byte-strobed stores become read-modify-write
// sequences because the RAM only writes whole words. All outputs are
// registered.
module mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int LANES = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR       = 3'd3,
    ST_RMW_RD   = 3'd4,
    ST_RMW_WAIT = 3'd5,
    ST_RMW_WR   = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

  state_t            state_r;
  logic              last_d_r;   // 1: most recent grant went to the data port
  logic              gnt_d_r;    // 1: access in flight belongs to the data port
  logic [LANES-1:0]  wstrb_r;
  logic [DATA_W-1:0] wdata_r;

  logic              i_done_r;
  logic              d_done_r;
  logic [DATA_W-1:0] i_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              m_rd_en_r;
  logic              m_wr_en_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [DATA_W-1:0] m_wr_data_r;

  logic              grant_i_s;
  logic              grant_d_s;

  // Per-lane merge of store data over the word read back from RAM.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [LANES-1:0]  strb
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int n = 0; n < LANES; n++) begin
      if (strb[n]) begin
        res[8*n +: 8] = new_word[8*n +: 8];
      end else begin
        res[8*n +: 8] = old_word[8*n +: 8];
      end
    end
    return res;
  endfunction

  // Round-robin grant decision, only meaningful while idle.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == ST_IDLE) begin
      grant_d_s = bus.d_req && (!bus.i_req || !last_d_r);
      grant_i_s = bus.i_req && !grant_d_s;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Access sequencer: grant, RAM handshake, RMW merge and done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_d_r    <= 1'b1;
      gnt_d_r     <= 1'b0;
      wstrb_r     <= {LANES{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      i_done_r    <= 1'b0;
      d_done_r    <= 1'b0;
      i_rdata_r   <= {DATA_W{1'b0}};
      d_rdata_r   <= {DATA_W{1'b0}};
      m_rd_en_r   <= 1'b0;
      m_wr_en_r   <= 1'b0;
      m_addr_r    <= {ADDR_W{1'b0}};
      m_wr_data_r <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_i_s) begin
            last_d_r  <= 1'b0;
            gnt_d_r   <= 1'b0;
            m_addr_r  <= bus.i_addr;
            m_rd_en_r <= 1'b1;
            state_r   <= ST_RD;
          end else if (grant_d_s) begin
            last_d_r <= 1'b1;
            gnt_d_r  <= 1'b1;
            m_addr_r <= bus.d_addr;
            wdata_r  <= bus.d_wdata;
            wstrb_r  <= bus.d_wstrb;
            if (!bus.d_we) begin
              m_rd_en_r <= 1'b1;
              state_r   <= ST_RD;
            end else if (bus.d_wstrb == {LANES{1'b1}}) begin
              m_wr_en_r   <= 1'b1;
              m_wr_data_r <= bus.d_wdata;
              state_r     <= ST_WR;
            end else if (bus.d_wstrb == {LANES{1'b0}}) begin
              // nothing to write: complete without touching the RAM
              d_done_r <= 1'b1;
              state_r  <= ST_DONE;
            end else begin
              m_rd_en_r <= 1'b1;
              state_r   <= ST_RMW_RD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          m_rd_en_r <= 1'b0;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (bus.m_rd_valid) begin
            if (gnt_d_r) begin
              d_rdata_r <= bus.m_rd_data;
              d_done_r  <= 1'b1;
            end else begin
              i_rdata_r <= bus.m_rd_data;
              i_done_r  <= 1'b1;
            end
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_RD_WAIT;
          end
        end
        ST_WR: begin
          m_wr_en_r <= 1'b0;
          d_done_r  <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_RMW_RD: begin
          m_rd_en_r <= 1'b0;
          state_r   <= ST_RMW_WAIT;
        end
        ST_RMW_WAIT: begin
          if (bus.m_rd_valid) begin
            m_wr_data_r <= merge_lanes(bus.m_rd_data, wdata_r, wstrb_r);
            m_wr_en_r   <= 1'b1;
            state_r     <= ST_RMW_WR;
          end else begin
            state_r <= ST_RMW_WAIT;
          end
        end
        ST_RMW_WR: begin
          m_wr_en_r <= 1'b0;
          d_done_r  <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          // requesters react to done this cycle; next grant is next cycle
          i_done_r <= 1'b0;
          d_done_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          i_done_r  <= 1'b0;
          d_done_r  <= 1'b0;
          m_rd_en_r <= 1'b0;
          m_wr_en_r <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.i_done    = i_done_r;
  assign bus.d_done    = d_done_r;
  assign bus.i_rdata   = i_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.m_rd_en   = m_rd_en_r;
  assign bus.m_wr_en   = m_wr_en_r;
  assign bus.m_addr    = m_addr_r;
  assign bus.m_wr_data = m_wr_data_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural RAM responder plus a
// word-level reference memory that predicts read data, store merges,
// latencies and grant order.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mem_arbiter_if #(.ADDR_W(13)) bus();

  mem_arbiter #(.ADDR_W(13), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // RAM responder controls
  bit          ram_init  = 1'b0;
  bit          stale_inj = 1'b0;
  bit          pl_en     = 1'b0;
  logic [10:0] pl_idx    = 11'd0;
  logic [31:0] pl_val    = 32'd0;
  logic [31:0] ram [0:2047];

  // reference memory contents
  logic [31:0] ref_mem [0:2047];

  function automatic logic [31:0] init_val(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Store rule: each enabled byte lane takes the store byte.
  function automatic logic [31:0] apply_store(input logic [31:0] old_w,
                                              input logic [31:0] wd,
                                              input logic [3:0]  strb);
    logic [31:0] mask;
    mask = 32'd0;
    for (int n = 0; n < 4; n++)
      if (strb[n]) mask = mask | (32'hFF << (8 * n));
    return (old_w & ~mask) | (wd & mask);
  endfunction

  // Single-port RAM with one-cycle read latency.
  always @(posedge clk) begin
    bus.m_rd_valid <= bus.m_rd_en | stale_inj;
    bus.m_rd_data  <= stale_inj ? 32'hBAD0BAD0 : ram[bus.m_addr[12:2]];
    if (ram_init) begin
      for (int i = 0; i < 2048; i++) ram[i] <= init_val(i);
    end else begin
      if (bus.m_wr_en) ram[bus.m_addr[12:2]] <= bus.m_wr_data;
      if (pl_en) ram[pl_idx] <= pl_val;
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    pl_idx = 11'(idx);
    pl_val = val;
    pl_en  = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
    ref_mem[idx] = val;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drive one single-port transaction starting in an idle cycle (cycle 0)
  // and record what the DUT does; inputs are scrambled after the grant.
  task automatic run_txn(input bit is_d, input bit we, input logic [12:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         output int lat, output logic [31:0] rdata,
                         output int nrd, output int nwr, output int rd_cyc,
                         output int wr_cyc, output logic [31:0] wr_dat,
                         output bit other_done, output bit both_hi);
    lat = -1; rdata = 32'd0; nrd = 0; nwr = 0; rd_cyc = -1; wr_cyc = -1;
    wr_dat = 32'd0; other_done = 1'b0; both_hi = 1'b0;
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr;
      bus.d_wdata = wdata; bus.d_wstrb = strb;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.m_rd_en) begin nrd++; if (rd_cyc < 0) rd_cyc = k; end
      if (bus.m_wr_en) begin
        nwr++;
        if (wr_cyc < 0) begin wr_cyc = k; wr_dat = bus.m_wr_data; end
      end
      if (bus.m_rd_en && bus.m_wr_en) both_hi = 1'b1;
      if (is_d ? bus.i_done : bus.d_done) other_done = 1'b1;
      if (k == 1) begin
        bus.d_addr = 13'($urandom); bus.d_wdata = $urandom;
        bus.d_wstrb = 4'($urandom); bus.d_we = 1'($urandom);
        bus.i_addr = 13'($urandom);
      end
      if (is_d ? bus.d_done : bus.i_done) begin
        lat = k;
        rdata = is_d ? bus.d_rdata : bus.i_rdata;
        break;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({bus.i_done, bus.d_done, bus.m_rd_en, bus.m_wr_en} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000",
               {bus.i_done, bus.d_done, bus.m_rd_en, bus.m_wr_en});
    else n_pass++;
    n_checks++;
    if ({bus.i_rdata, bus.d_rdata, bus.m_wr_data, bus.m_addr} !== 109'd0)
      $display("FAIL reset_data: got %h/%h/%h/%h want 0", bus.i_rdata,
               bus.d_rdata, bus.m_wr_data, bus.m_addr);
    else n_pass++;
  endtask

  task automatic test_fetch();
    int lat, nrd, nwr, rc, wc; logic [31:0] rd, wd; bit od, bh;
    preload(5, 32'hDEADBEEF);
    run_txn(1'b0, 1'b0, 13'h014, 32'd0, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (lat !== 3) $display("FAIL fetch_lat: got %0d want 3", lat); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL fetch_data: got %h want deadbeef", rd); else n_pass++;
    n_checks++; if (rc !== 1 || nrd !== 1 || nwr !== 0)
      $display("FAIL fetch_ram: got rd_cyc %0d nrd %0d nwr %0d want 1 1 0", rc, nrd, nwr); else n_pass++;
    n_checks++; if (od !== 1'b0) $display("FAIL fetch_d_done: got %b want 0", od); else n_pass++;
  endtask

  task automatic test_full_store();
    int lat, nrd, nwr, rc, wc; logic [31:0] rd, wd; bit od, bh;
    run_txn(1'b1, 1'b1, 13'h020, 32'h12345678, 4'hF, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    ref_mem[8] = apply_store(ref_mem[8], 32'h12345678, 4'hF);
    n_checks++; if (lat !== 2) $display("FAIL full_lat: got %0d want 2", lat); else n_pass++;
    n_checks++; if (wc !== 1 || nwr !== 1 || nrd !== 0)
      $display("FAIL full_ram: got wr_cyc %0d nwr %0d nrd %0d want 1 1 0", wc, nwr, nrd); else n_pass++;
    n_checks++; if (wd !== ref_mem[8]) $display("FAIL full_wdata: got %h want %h", wd, ref_mem[8]); else n_pass++;
    run_txn(1'b1, 1'b0, 13'h020, 32'd0, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (lat !== 3 || rd !== 32'h12345678)
      $display("FAIL full_readback: got lat %0d data %h want 3 12345678", lat, rd); else n_pass++;
  endtask

  task automatic test_partial_store();
    int lat, nrd, nwr, rc, wc; logic [31:0] rd, wd, exp; bit od, bh;
    preload(16, 32'h11223344);
    exp = apply_store(ref_mem[16], 32'h0000AB00, 4'b0010);
    run_txn(1'b1, 1'b1, 13'h040, 32'h0000AB00, 4'b0010, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    ref_mem[16] = exp;
    n_checks++; if (rc !== 1 || wc !== 3 || nrd !== 1 || nwr !== 1)
      $display("FAIL rmw_seq: got rd %0d wr %0d nrd %0d nwr %0d want 1 3 1 1", rc, wc, nrd, nwr); else n_pass++;
    n_checks++; if (wd !== 32'h1122AB44) $display("FAIL rmw_merge: got %h want 1122ab44", wd); else n_pass++;
    n_checks++; if (lat !== 4) $display("FAIL rmw_lat: got %0d want 4", lat); else n_pass++;
    run_txn(1'b1, 1'b0, 13'h040, 32'd0, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (rd !== exp) $display("FAIL rmw_readback: got %h want %h", rd, exp); else n_pass++;
  endtask

  task automatic test_zero_strobe();
    int lat, nrd, nwr, rc, wc; logic [31:0] rd, wd; bit od, bh;
    run_txn(1'b1, 1'b1, 13'h020, 32'hFFFFFFFF, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (lat !== 1) $display("FAIL zero_lat: got %0d want 1", lat); else n_pass++;
    n_checks++; if (nrd !== 0 || nwr !== 0)
      $display("FAIL zero_ram: got nrd %0d nwr %0d want 0 0", nrd, nwr); else n_pass++;
    run_txn(1'b1, 1'b0, 13'h020, 32'd0, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (rd !== ref_mem[8]) $display("FAIL zero_unchanged: got %h want %h", rd, ref_mem[8]); else n_pass++;
  endtask

  task automatic test_random();
    int lat, nrd, nwr, rc, wc, kind, idx, exp_lat, exp_rd, exp_wr;
    logic [31:0] rd, wd, wdata, exp_w; logic [12:0] addr; logic [3:0] strb; bit od, bh;
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(2, 0);
      addr = 13'($urandom); wdata = $urandom; strb = 4'($urandom);
      idx = int'(addr[12:2]);
      if (kind == 2) begin
        exp_w = apply_store(ref_mem[idx], wdata, strb);
        exp_lat = (strb == 4'hF) ? 2 : (strb == 4'h0) ? 1 : 4;
        exp_rd = (strb == 4'hF || strb == 4'h0) ? 0 : 1;
        exp_wr = (strb == 4'h0) ? 0 : 1;
      end else begin
        exp_w = ref_mem[idx]; exp_lat = 3; exp_rd = 1; exp_wr = 0;
      end
      run_txn(kind != 0, kind == 2, addr, wdata, strb, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
      n_checks++; if (lat !== exp_lat || nrd !== exp_rd || nwr !== exp_wr)
        $display("FAIL rand_timing[%0d]: got lat %0d nrd %0d nwr %0d want %0d %0d %0d",
                 t, lat, nrd, nwr, exp_lat, exp_rd, exp_wr); else n_pass++;
      if (kind != 2) begin
        n_checks++; if (rd !== exp_w) $display("FAIL rand_rdata[%0d]: got %h want %h", t, rd, exp_w); else n_pass++;
      end else if (exp_wr == 1) begin
        n_checks++; if (wd !== exp_w) $display("FAIL rand_wdata[%0d]: got %h want %h", t, wd, exp_w); else n_pass++;
      end
      n_checks++; if (od !== 1'b0 || bh !== 1'b0)
        $display("FAIL rand_side[%0d]: got other_done %b both_en %b want 0 0", t, od, bh); else n_pass++;
      ref_mem[idx] = exp_w;
    end
  endtask

  task automatic test_arbitration();
    logic [12:0] ia, da; int got; bit both_hi; logic [31:0] exp;
    apply_reset();
    ia = 13'($urandom); da = 13'($urandom);
    bus.i_addr = ia; bus.d_addr = da; bus.d_we = 1'b0; bus.d_wstrb = 4'h0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    got = 0; both_hi = 1'b0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(posedge clk); #1;
      if (bus.m_rd_en && bus.m_wr_en) both_hi = 1'b1;
      if (bus.i_done || bus.d_done) begin
        n_checks++;
        if (bus.i_done !== (got % 2 == 0) || bus.d_done !== (got % 2 == 1))
          $display("FAIL arb_order[%0d]: got i_done %b d_done %b want %s",
                   got, bus.i_done, bus.d_done, (got % 2 == 0) ? "I" : "D");
        else n_pass++;
        exp = bus.i_done ? ref_mem[ia[12:2]] : ref_mem[da[12:2]];
        n_checks++;
        if ((bus.i_done ? bus.i_rdata : bus.d_rdata) !== exp)
          $display("FAIL arb_data[%0d]: got %h want %h", got,
                   bus.i_done ? bus.i_rdata : bus.d_rdata, exp);
        else n_pass++;
        if (bus.i_done) begin ia = 13'($urandom); bus.i_addr = ia; end
        else begin da = 13'($urandom); bus.d_addr = da; end
        got++;
      end
    end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    n_checks++; if (got !== 4) $display("FAIL arb_count: got %0d want 4", got); else n_pass++;
    n_checks++; if (both_hi !== 1'b0) $display("FAIL arb_exclusive: got %b want 0", both_hi); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int lat, nrd, nwr, rc, wc; logic [31:0] rd, wd; bit od, bh, seen;
    bus.i_req = 1'b1; bus.i_addr = 13'h014;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.i_done, bus.d_done, bus.m_rd_en, bus.m_wr_en} !== 4'b0000 ||
        {bus.i_rdata, bus.d_rdata, bus.m_wr_data, bus.m_addr} !== 109'd0)
      $display("FAIL abort_outputs: got ctrl %b rdata %h want all 0",
               {bus.i_done, bus.d_done, bus.m_rd_en, bus.m_wr_en}, bus.i_rdata);
    else n_pass++;
    bus.i_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale_inj = 1'b1;
    @(posedge clk); #1;
    stale_inj = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.i_done || bus.d_done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0 || bus.i_rdata !== 32'd0)
      $display("FAIL abort_stale: got done %b i_rdata %h want 0 0", seen, bus.i_rdata); else n_pass++;
    run_txn(1'b0, 1'b0, 13'h014, 32'd0, 4'h0, lat, rd, nrd, nwr, rc, wc, wd, od, bh);
    n_checks++; if (lat !== 3 || rd !== ref_mem[5])
      $display("FAIL abort_refetch: got lat %0d data %h want 3 %h", lat, rd, ref_mem[5]); else n_pass++;
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 13'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 13'd0;
    bus.d_wdata = 32'd0; bus.d_wstrb = 4'h0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(i);
    ram_init = 1'b1;
    test_reset();
    apply_reset();
    ram_init = 1'b0;
    test_fetch();
    test_full_store();
    test_partial_store();
    test_zero_strobe();
    test_random();
    test_arbitration();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
